// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO, with a busy countdown per operation class.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation into HI/LO.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Req,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] MDUOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, nextState;
    logic [CW-1:0] count;
    logic [31:0]   opA, opB;
    logic [3:0]    pendOp;
    logic          isMult, isDiv, lastCycle;

    logic          mulSigned, divSigned, commitEn;
    logic [63:0]   extA, extB, product;
    logic [31:0]   magA, magB, quotMag, remMag, quot, rem;
    logic [31:0]   commitHi, commitLo;

    always_comb begin
        isMult = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_MADD_EN
        isMult = isMult || (MDUOp >= OP_MADD && MDUOp <= OP_MSUBU);
`endif
        isDiv  = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
        Start  = (isMult || isDiv) && !Req && !Busy;
    end

    assign Busy      = (state == RUN);
    assign lastCycle = (count == CW'(1));

    always_comb begin
        MDUOut = '0;
        if (MDUOp == OP_MFHI) MDUOut = HI;
        else if (MDUOp == OP_MFLO) MDUOut = LO;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start) nextState = RUN;
            RUN:     if (lastCycle) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Signed division works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    always_comb begin
        mulSigned = (pendOp == OP_MULT);
`ifdef MDU_MADD_EN
        mulSigned = mulSigned || (pendOp == OP_MADD) || (pendOp == OP_MSUB);
`endif
        extA    = mulSigned ? {{32{opA[31]}}, opA} : {32'b0, opA};
        extB    = mulSigned ? {{32{opB[31]}}, opB} : {32'b0, opB};
        product = extA * extB;

        divSigned = (pendOp == OP_DIV);
        magA      = (divSigned && opA[31]) ? -opA : opA;
        magB      = (divSigned && opB[31]) ? -opB : opB;
        quotMag   = magA / magB;
        remMag    = magA % magB;
        quot      = (divSigned && (opA[31] ^ opB[31])) ? -quotMag : quotMag;
        rem       = (divSigned && opA[31]) ? -remMag : remMag;

        commitEn = 1'b1;
        {commitHi, commitLo} = product;
        case (pendOp)
            OP_DIV, OP_DIVU: begin
                commitEn = (opB != 32'd0);
                commitHi = rem;
                commitLo = quot;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: {commitHi, commitLo} = {HI, LO} + product;
            OP_MSUB, OP_MSUBU: {commitHi, commitLo} = {HI, LO} - product;
`endif
            default: ;
        endcase
    end

    // Operands are latched at Start so forwarding changes during RUN cannot disturb the result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            HI     <= '0;
            LO     <= '0;
            count  <= '0;
            opA    <= '0;
            opB    <= '0;
            pendOp <= OP_NOP;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        opA    <= A;
                        opB    <= B;
                        pendOp <= MDUOp;
                        count  <= isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    end else if (!Req) begin
                        if (MDUOp == OP_MTHI) HI <= A;
                        if (MDUOp == OP_MTLO) LO <= A;
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (lastCycle) begin
                        pendOp <= OP_NOP;
                        if (commitEn) begin
                            HI <= commitHi;
                            LO <= commitLo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
